instr_fetch_unit: RTL and testbench

Front-end sequencer of the accumulator CPU. It fetches one instruction word per step from instruction memory over a req/ack handshake and holds it in the instruction register. It presents the 6-bit opcode and the operand to the control unit and execute stage, then computes the next PC: sequential, conditional branch, unconditional branch, jump-with-return, or return. A small internal return-address stack serves jmp/ret.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/ret_stack.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU front end.
//   - opcode encodings (6-bit, top bits of the instruction word)
//   - flag bit positions within the {Z,N,C,O} flag vector
//   - fetch sequencer state encoding
package cpu_pkg;

  localparam logic [5:0] OP_BRZ = 6'd0;
  localparam logic [5:0] OP_BRN = 6'd1;
  localparam logic [5:0] OP_BRC = 6'd2;
  localparam logic [5:0] OP_BRO = 6'd3;
  localparam logic [5:0] OP_LDI = 6'd4;
  localparam logic [5:0] OP_LDA = 6'd5;
  localparam logic [5:0] OP_BRA = 6'd6;
  localparam logic [5:0] OP_JMP = 6'd7;
  localparam logic [5:0] OP_RET = 6'd8;
  localparam logic [5:0] OP_ADD = 6'd9;
  localparam logic [5:0] OP_SUB = 6'd10;
  localparam logic [5:0] OP_ADC = 6'd11;
  localparam logic [5:0] OP_SBC = 6'd12;
  localparam logic [5:0] OP_AND = 6'd13;
  localparam logic [5:0] OP_OR  = 6'd14;
  localparam logic [5:0] OP_XOR = 6'd15;
  localparam logic [5:0] OP_NOT = 6'd16;
  localparam logic [5:0] OP_SHL = 6'd17;
  localparam logic [5:0] OP_SHR = 6'd18;
  localparam logic [5:0] OP_ROL = 6'd19;
  localparam logic [5:0] OP_ROR = 6'd20;
  localparam logic [5:0] OP_STA = 6'd21;
  localparam logic [5:0] OP_CMP = 6'd22;
  localparam logic [5:0] OP_NOP = 6'd23;
  localparam logic [5:0] OP_CLR = 6'd24;
  localparam logic [5:0] OP_INC = 6'd25;
  localparam logic [5:0] OP_DEC = 6'd26;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for jmp/ret.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (empties the stack)
//   i_push, i_data     push i_data (dropped when full)
//   i_pop              discard top entry (ignored when empty)
//   o_full, o_empty    occupancy status
//   o_top              most recently pushed entry (undefined when empty)
module ret_stack #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W-1:0] o_top
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_sp == SP_W'(STACK_DEPTH));
  assign o_empty   = (r_sp == '0);
  assign w_wr_idx  = r_sp[PTR_W-1:0];
  assign w_top_idx = w_wr_idx - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];

  // A simultaneous push and pop never comes from the fetch unit; treat it as a no-op.
  assign w_do_push = i_push & ~i_pop & ~o_full;
  assign w_do_pop  = i_pop & ~i_push & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  // Storage needs no reset: entries are only readable below sp.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: fetches one word per step over a req/ack
// handshake, issues opcode/operand downstream, and computes the next pc
// (sequential, conditional/unconditional branch, jmp/ret via ret_stack).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   imem_req, imem_addr              fetch request/address (decoded from state, pc)
//   imem_ack, imem_rdata             memory response, sampled only in FETCH
//   flags                            {Z,N,C,O} from execute, sampled on issue accept
//   op_code, operand, instr_valid    current instruction to control/execute
//   instr_ready                      downstream accepts current instruction
//   pc                               address of current/next fetch
//   stack_err                        sticky return-stack overflow/underflow
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | post-reset, moves to FETCH next cycle
// FETCH | imem_req high at pc; load ir on imem_ack
// ISSUE | instr_valid high; on instr_ready update pc, back to FETCH
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic [3:0]         flags,
  output logic [5:0]         op_code,
  output logic [ADDR_W-1:0]  operand,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               stack_err
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_stack_err;
  logic               w_ir_load;
  logic               w_pc_load;
  logic               w_push;
  logic               w_pop;
  logic               w_err_set;
  logic               w_stk_full;
  logic               w_stk_empty;
  logic [ADDR_W-1:0]  w_stk_top;
  logic [5:0]         w_opcode;
  logic [ADDR_W-1:0]  w_operand;

  // op_code/operand come straight from ir, which only loads on FETCH->ISSUE.
  assign w_opcode  = r_ir[INSTR_W-1 -: 6];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_pc_inc  = r_pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_stack_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_load) begin
        r_ir <= imem_rdata;
      end
      if (w_pc_load) begin
        r_pc <= w_pc_nxt;
      end
      if (w_err_set) begin
        r_stack_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_pc_load   = 1'b0;
    w_pc_nxt    = w_pc_inc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          w_ir_load   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          w_pc_load   = 1'b1;
          w_state_nxt = ST_FETCH;
          case (w_opcode)
            OP_BRZ: if (flags[FLAG_Z]) w_pc_nxt = w_operand;
            OP_BRN: if (flags[FLAG_N]) w_pc_nxt = w_operand;
            OP_BRC: if (flags[FLAG_C]) w_pc_nxt = w_operand;
            OP_BRO: if (flags[FLAG_O]) w_pc_nxt = w_operand;
            OP_BRA: w_pc_nxt = w_operand;
            OP_JMP: begin
              // Jump is taken even when the return address cannot be saved.
              w_pc_nxt = w_operand;
              if (w_stk_full) w_err_set = 1'b1;
              else            w_push    = 1'b1;
            end
            OP_RET: begin
              if (w_stk_empty) begin
                w_err_set = 1'b1;
              end else begin
                w_pop    = 1'b1;
                w_pc_nxt = w_stk_top;
              end
            end
            default: ;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_ISSUE);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign op_code     = w_opcode;
  assign operand     = w_operand;
  assign stack_err   = r_stack_err;

  ret_stack #(
    .ADDR_W     (ADDR_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (w_pc_inc),
    .o_full (w_stk_full),
    .o_empty(w_stk_empty),
    .o_top  (w_stk_top)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;
  localparam int AMOD    = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic [3:0]         flags = '0;
  logic [5:0]         op_code;
  logic [ADDR_W-1:0]  operand;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic [ADDR_W-1:0]  pc;
  logic               stack_err;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .flags(flags),
    .op_code(op_code), .operand(operand), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [INSTR_W-1:0] imem [AMOD];

  // reference model state
  int m_pc;
  int m_stack[$];
  bit m_err;

  // observations from the last step
  logic [ADDR_W-1:0] obs_addr;
  logic [5:0]        obs_op;
  logic [ADDR_W-1:0] obs_opnd;
  int                obs_req;
  bit                obs_stable;
  bit                obs_tout;

  function automatic void model_reset();
    m_pc = 0;
    m_stack.delete();
    m_err = 1'b0;
  endfunction

  // Next-pc rules expressed directly on integers.
  function automatic void model_step(input logic [INSTR_W-1:0] w, input logic [3:0] f);
    int op, tgt, nxt;
    op  = int'(w[15:10]);
    tgt = int'(w[9:0]);
    nxt = (m_pc + 1) % AMOD;
    if (op == 0)      m_pc = f[3] ? tgt : nxt;
    else if (op == 1) m_pc = f[2] ? tgt : nxt;
    else if (op == 2) m_pc = f[1] ? tgt : nxt;
    else if (op == 3) m_pc = f[0] ? tgt : nxt;
    else if (op == 6) m_pc = tgt;
    else if (op == 7) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(nxt);
      else m_err = 1'b1;
      m_pc = tgt;
    end else if (op == 8) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_err = 1'b1;
        m_pc = nxt;
      end
    end else m_pc = nxt;
  endfunction

  function automatic logic [INSTR_W-1:0] mk(input int op, input int tgt);
    logic [5:0] o;
    logic [ADDR_W-1:0] t;
    o = 6'(op);
    t = ADDR_W'(tgt);
    return {o, t};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one full fetch/issue transaction. Called just after a rising edge.
  task automatic step(input int ack_dly, input int stall, input logic [3:0] f);
    int n;
    logic [ADDR_W-1:0] pc0;
    obs_tout = 1'b0; obs_req = 0; obs_stable = 1'b1; n = 0;
    obs_addr = '0; obs_op = '0; obs_opnd = '0;
    while (!imem_req && n < 8) begin
      @(posedge clk); #1; n++;
    end
    if (!imem_req) begin
      obs_tout = 1'b1;
      return;
    end
    obs_addr = imem_addr;
    for (int i = 0; i < ack_dly; i++) begin
      if (imem_req) obs_req++;
      if (imem_addr !== obs_addr) obs_stable = 1'b0;
      @(posedge clk); #1;
    end
    if (imem_req) obs_req++;
    imem_ack = 1'b1;
    imem_rdata = imem[obs_addr];
    @(posedge clk); #1;
    if (!instr_valid) begin
      imem_ack = 1'b0;
      obs_tout = 1'b1;
      return;
    end
    obs_op = op_code; obs_opnd = operand; pc0 = pc;
    for (int i = 0; i < stall; i++) begin
      // acks outside FETCH must be ignored
      imem_ack = 1'b1;
      imem_rdata = INSTR_W'($urandom);
      flags = 4'($urandom);
      instr_ready = 1'b0;
      @(posedge clk); #1;
      if (op_code !== obs_op || operand !== obs_opnd || pc !== pc0 || !instr_valid)
        obs_stable = 1'b0;
    end
    flags = f;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    imem_ack = 1'b0;
    flags = 4'($urandom);
  endtask

  // Places word at the model pc, runs it, and advances the model.
  task automatic run(input logic [INSTR_W-1:0] w, input int ad, input int st, input logic [3:0] f);
    imem[m_pc[ADDR_W-1:0]] = w;
    step(ad, st, f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl req=%b valid=%b err=%b expected 0 0 0", imem_req, instr_valid, stack_err);
    end
    checks++;
    if (pc !== '0 || op_code !== '0 || operand !== '0) begin
      failures++;
      $display("FAIL reset_regs pc=%h op=%h opnd=%h expected 0 0 0", pc, op_code, operand);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      failures++;
      $display("FAIL first_req req=%b addr=%h expected 1 000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run(16'h2400, 0, 0, 4'hF);
      checks++;
      if (obs_tout || obs_addr !== ADDR_W'(m_pc) || obs_op !== 6'b001001 || obs_req != 1) begin
        failures++;
        $display("FAIL seq_fetch i=%0d addr=%h op=%b req=%0d tout=%b expected addr=%h op=001001 req=1",
                 i, obs_addr, obs_op, obs_req, obs_tout, m_pc);
      end
      model_step(16'h2400, 4'hF);
      checks++;
      if (pc !== ADDR_W'(m_pc) || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
        failures++;
        $display("FAIL seq_pc i=%0d pc=%h valid=%b req=%b expected %h 0 1", i, pc, instr_valid, imem_req, m_pc);
      end
    end
  endtask

  task automatic test_wait_stall();
    logic [INSTR_W-1:0] w;
    w = mk(13, 10'h2AB);
    run(w, 3, 2, 4'h0);
    checks++;
    if (obs_tout || obs_req != 4 || !obs_stable || obs_op !== 6'd13 || obs_opnd !== 10'h2AB) begin
      failures++;
      $display("FAIL wait_stall req=%0d stable=%b op=%h opnd=%h tout=%b expected 4 1 0d 2ab",
               obs_req, obs_stable, obs_op, obs_opnd, obs_tout);
    end
    model_step(w, 4'h0);
    checks++;
    if (pc !== ADDR_W'(m_pc)) begin
      failures++;
      $display("FAIL wait_stall_pc pc=%h expected %h", pc, m_pc);
    end
  endtask

  task automatic test_cond_branch();
    logic [INSTR_W-1:0] w;
    logic [3:0] f;
    for (int op = 0; op < 4; op++) begin
      for (int tk = 0; tk < 2; tk++) begin
        w = mk(op, 'h155);
        f = 4'($urandom);
        f[3-op] = tk[0];
        run(w, $urandom_range(0, 1), $urandom_range(0, 1), f);
        model_step(w, f);
        checks++;
        if (obs_tout || pc !== ADDR_W'(m_pc) || imem_addr !== ADDR_W'(m_pc)) begin
          failures++;
          $display("FAIL cond_branch op=%0d taken=%0d addr=%h tout=%b expected %h", op, tk, imem_addr, obs_tout, m_pc);
        end
      end
    end
  endtask

  task automatic test_jmp_ret();
    do_reset();
    run(mk(6, 'h010), 0, 0, 4'h0); model_step(mk(6, 'h010), 4'h0);
    run(mk(7, 'h200), 0, 0, 4'h0); model_step(mk(7, 'h200), 4'h0);
    checks++;
    if (obs_tout || obs_addr !== 10'h010 || imem_addr !== 10'h200) begin
      failures++;
      $display("FAIL jmp_target from=%h addr=%h tout=%b expected from 010 to 200", obs_addr, imem_addr, obs_tout);
    end
    run(mk(8, 0), 1, 1, 4'h0); model_step(mk(8, 0), 4'h0);
    checks++;
    if (obs_tout || imem_addr !== 10'h011 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL ret_target addr=%h err=%b tout=%b expected 011 0", imem_addr, stack_err, obs_tout);
    end
  endtask

  task automatic test_stack_err();
    logic [INSTR_W-1:0] w;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      w = mk(7, 'h40 * i + 'h20);
      run(w, 0, 0, 4'h0);
      model_step(w, 4'h0);
      checks++;
      if (obs_tout || pc !== ADDR_W'(m_pc) || stack_err !== m_err) begin
        failures++;
        $display("FAIL overflow_jmp n=%0d pc=%h err=%b expected %h %b", i, pc, stack_err, m_pc, m_err);
      end
    end
    for (int i = 0; i < 5; i++) begin
      run(mk(8, 0), 0, 0, 4'h0);
      model_step(mk(8, 0), 4'h0);
      checks++;
      if (obs_tout || pc !== ADDR_W'(m_pc) || stack_err !== m_err) begin
        failures++;
        $display("FAIL unwind_ret n=%0d pc=%h err=%b expected %h %b", i, pc, stack_err, m_pc, m_err);
      end
    end
    do_reset();
    checks++;
    if (stack_err !== 1'b0) begin
      failures++;
      $display("FAIL err_reset err=%b expected 0", stack_err);
    end
    run(mk(6, 'h005), 0, 0, 4'h0); model_step(mk(6, 'h005), 4'h0);
    run(mk(8, 0), 0, 0, 4'h0); model_step(mk(8, 0), 4'h0);
    checks++;
    if (obs_tout || imem_addr !== 10'h006 || stack_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow addr=%h err=%b expected 006 1", imem_addr, stack_err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run(mk(6, 'h3FF), 0, 0, 4'h0); model_step(mk(6, 'h3FF), 4'h0);
    run(16'h2400, 0, 0, 4'h0); model_step(16'h2400, 4'h0);
    checks++;
    if (obs_tout || obs_addr !== 10'h3FF || imem_addr !== 10'h000) begin
      failures++;
      $display("FAIL wrap_seq from=%h addr=%h expected 3ff 000", obs_addr, imem_addr);
    end
    run(mk(6, 'h3FF), 0, 0, 4'h0); model_step(mk(6, 'h3FF), 4'h0);
    run(mk(7, 'h050), 0, 0, 4'h0); model_step(mk(7, 'h050), 4'h0);
    run(mk(8, 0), 0, 0, 4'h0); model_step(mk(8, 0), 4'h0);
    checks++;
    if (obs_tout || imem_addr !== 10'h000 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_push addr=%h err=%b expected 000 0", imem_addr, stack_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(mk(7, 'h123), 0, 0, 4'h0); model_step(mk(7, 'h123), 4'h0);
    // reach ISSUE at 0x123 and reset while ready is asserted
    imem_ack = 1'b1;
    imem_rdata = 16'h2400;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || pc !== '0 || imem_req !== 1'b0 || op_code !== '0) begin
      failures++;
      $display("FAIL reset_issue valid=%b pc=%h req=%b op=%h expected 0 000 0 00", instr_valid, pc, imem_req, op_code);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      failures++;
      $display("FAIL reset_refetch req=%b addr=%h expected 1 000", imem_req, imem_addr);
    end
    // stack must have been emptied
    run(mk(8, 0), 0, 0, 4'h0); model_step(mk(8, 0), 4'h0);
    checks++;
    if (obs_tout || pc !== 10'h001 || stack_err !== 1'b1) begin
      failures++;
      $display("FAIL reset_stack pc=%h err=%b expected 001 1", pc, stack_err);
    end
    // reset in FETCH with a concurrent ack discards the word
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || op_code !== '0 || operand !== '0 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_fetch valid=%b op=%h opnd=%h err=%b expected 0 00 000 0", instr_valid, op_code, operand, stack_err);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [INSTR_W-1:0] w;
    logic [3:0] f;
    int op;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9));
      w = mk(op, int'($urandom_range(0, AMOD - 1)));
      f = 4'($urandom);
      run(w, $urandom_range(0, 2), $urandom_range(0, 2), f);
      checks++;
      if (obs_tout || obs_addr !== ADDR_W'(m_pc) || obs_op !== w[15:10] || obs_opnd !== w[9:0] || !obs_stable) begin
        failures++;
        $display("FAIL rand_fetch i=%0d addr=%h op=%h opnd=%h stable=%b expected %h %h %h 1",
                 i, obs_addr, obs_op, obs_opnd, obs_stable, m_pc, w[15:10], w[9:0]);
      end
      model_step(w, f);
      checks++;
      if (pc !== ADDR_W'(m_pc) || stack_err !== m_err) begin
        failures++;
        $display("FAIL rand_next i=%0d pc=%h err=%b expected %h %b", i, pc, stack_err, m_pc, m_err);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < AMOD; i++) imem[i] = 16'h2400;
    model_reset();
    test_reset();
    test_sequential();
    test_wait_stall();
    test_cond_branch();
    test_jmp_ret();
    test_stack_err();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
